// File: rtl/micro_pkg.sv
// micro_pkg: request classes, the legal 4-bit bus codes, sequencer FSM states
// and the (class, select) -> code encoder shared by the issue side.
package micro_pkg;

  typedef enum logic [1:0] {
    CLS_A   = 2'd0,
    CLS_L   = 2'd1,
    CLS_B   = 2'd2,
    CLS_NOP = 2'd3
  } req_class_e;

  localparam logic [3:0] CODE_A0  = 4'b1010;
  localparam logic [3:0] CODE_A1  = 4'b1011;
  localparam logic [3:0] CODE_A2  = 4'b1100;
  localparam logic [3:0] CODE_L0  = 4'b0011;
  localparam logic [3:0] CODE_L1  = 4'b0100;
  localparam logic [3:0] CODE_L2  = 4'b0010;
  localparam logic [3:0] CODE_L3  = 4'b1110;
  localparam logic [3:0] CODE_B0  = 4'b1111;
  localparam logic [3:0] CODE_NOP = 4'b0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic       legal;
    logic [3:0] code;
  } enc_t;

  // Illegal combinations come back with legal=0 and the NOP code.
  function automatic enc_t encode_req(input logic [1:0] cls, input logic [1:0] sel);
    enc_t r;
    r.legal = 1'b1;
    r.code  = CODE_NOP;
    case (req_class_e'(cls))
      CLS_A: begin
        case (sel)
          2'd0:    r.code  = CODE_A0;
          2'd1:    r.code  = CODE_A1;
          2'd2:    r.code  = CODE_A2;
          default: r.legal = 1'b0;
        endcase
      end
      CLS_L: begin
        case (sel)
          2'd0:    r.code = CODE_L0;
          2'd1:    r.code = CODE_L1;
          2'd2:    r.code = CODE_L2;
          default: r.code = CODE_L3;
        endcase
      end
      CLS_B: begin
        if (sel == 2'd0) r.code  = CODE_B0;
        else             r.legal = 1'b0;
      end
      default: r.code = CODE_NOP;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/micro_fifo.sv
// micro_fifo: small synchronous FIFO holding encoded bus codes.
// Pointers carry one extra wrap bit so full/empty come from an MSB compare.
module micro_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Pointer advance; callers never push when full or pop when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset since empty masks them.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/micro_seq_v.sv
// micro_seq_v: queues (class, select) requests as 4-bit codes and issues them
// to the micro_v decoder, holding each code HOLD_CYC cycles with a GAP_CYC gap.
// Optional build macro MICRO_SEQ_ILLEGAL_CHK_EN: drop illegal requests and raise
// a sticky o_err (cleared by i_err_clr); without it illegal requests issue as NOP.
module micro_seq_v #(
  parameter int DEPTH    = 4,
  parameter int HOLD_CYC = 1,
  parameter int GAP_CYC  = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_req_valid,
  input  logic [1:0] i_req_class,
  input  logic [1:0] i_req_sel,
  output logic       o_req_ready,
  output logic       o_en,
  output logic [3:0] o_code,
  output logic       o_busy
`ifdef MICRO_SEQ_ILLEGAL_CHK_EN
  ,
  output logic       o_err,
  input  logic       i_err_clr
`endif
);

  import micro_pkg::*;

  localparam int CNT_MAX = (HOLD_CYC > GAP_CYC) ? ((HOLD_CYC > 2) ? HOLD_CYC : 2)
                                                : ((GAP_CYC > 2) ? GAP_CYC : 2);
  localparam int CW = $clog2(CNT_MAX);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  seq_state_e    state, state_nxt;
  logic [CW-1:0] hold_cnt, hold_nxt;
  logic [CW-1:0] gap_cnt, gap_nxt;
  logic [3:0]    cur_code, code_nxt;
  logic          pop;
  logic          push;
  logic [3:0]    push_code;
  logic [3:0]    fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          req_take;
  enc_t          req_enc;

  assign req_enc     = encode_req(i_req_class, i_req_sel);
  assign o_req_ready = !fifo_full;
  assign req_take    = i_req_valid && !fifo_full;
  assign o_busy      = !fifo_empty || (state != ST_IDLE);

`ifdef MICRO_SEQ_ILLEGAL_CHK_EN
  assign push      = req_take && req_enc.legal;
  assign push_code = req_enc.code;

  // Sticky illegal-request flag; a new illegal request beats a same-cycle clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                         o_err <= 1'b0;
    else if (req_take && !req_enc.legal)  o_err <= 1'b1;
    else if (i_err_clr)                   o_err <= 1'b0;
  end
`else
  assign push      = req_take;
  assign push_code = req_enc.legal ? req_enc.code : CODE_NOP;
`endif

  micro_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (4)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (push),
    .wdata (push_code),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // FSM state, hold/gap down-counters and the code currently being driven.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
      gap_cnt  <= '0;
      cur_code <= CODE_NOP;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      gap_cnt  <= gap_nxt;
      cur_code <= code_nxt;
    end
  end

  // Next-state: pop a new code on leaving IDLE, at the end of a gap, or at the
  // end of a hold when there is no gap phase.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    gap_nxt   = gap_cnt;
    code_nxt  = cur_code;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          code_nxt  = fifo_head;
          hold_nxt  = HOLD_LOAD;
          state_nxt = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (hold_cnt != '0) begin
          hold_nxt = hold_cnt - CW'(1);
        end else if (GAP_CYC > 0) begin
          gap_nxt   = GAP_LOAD;
          state_nxt = ST_GAP;
        end else if (!fifo_empty) begin
          pop      = 1'b1;
          code_nxt = fifo_head;
          hold_nxt = HOLD_LOAD;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_cnt != '0) begin
          gap_nxt = gap_cnt - CW'(1);
        end else if (!fifo_empty) begin
          pop       = 1'b1;
          code_nxt  = fifo_head;
          hold_nxt  = HOLD_LOAD;
          state_nxt = ST_DRIVE;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Registered bus outputs, one cycle behind the FSM; code forced to NOP when idle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_en   <= 1'b0;
      o_code <= CODE_NOP;
    end else begin
      o_en   <= (state == ST_DRIVE);
      o_code <= (state == ST_DRIVE) ? cur_code : CODE_NOP;
    end
  end

endmodule

// File: tb/tb_micro_seq_v.sv
// tb_micro_seq_v: two sequencer instances (default timing, and HOLD=2/GAP=0)
// driven with the same requests and compared against an issue-schedule model.
module tb_micro_seq_v;

  localparam int DEPTH  = 4;
  localparam int HOLD_A = 1;
  localparam int GAP_A  = 1;
  localparam int HOLD_B = 2;
  localparam int GAP_B  = 0;
  localparam int MAXR   = 1024;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [1:0] req_class = 2'd0;
  logic [1:0] req_sel = 2'd0;
  logic       ready_a, en_a, busy_a;
  logic       ready_b, en_b, busy_b;
  logic [3:0] code_a, code_b;
`ifdef MICRO_SEQ_ILLEGAL_CHK_EN
  logic       err_clr = 1'b0;
  logic       err_a, err_b;
`endif

  int t = 0;
  int n_pass = 0;
  int n_total = 0;

  // Model: per instance, every accepted request with its accept edge k,
  // the edge d at which it starts being driven, and its code.
  int         n_rec [2];
  int         rec_k [2][MAXR];
  int         rec_d [2][MAXR];
  logic [3:0] rec_code [2][MAXR];
  bit         err_exp [2];

  always #5 clk = ~clk;

  // Edge counter; after the n-th rising edge t equals n.
  always @(posedge clk) t <= t + 1;

  micro_seq_v #(.DEPTH(DEPTH), .HOLD_CYC(HOLD_A), .GAP_CYC(GAP_A)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .i_req_class(req_class),
    .i_req_sel(req_sel), .o_req_ready(ready_a), .o_en(en_a), .o_code(code_a), .o_busy(busy_a)
`ifdef MICRO_SEQ_ILLEGAL_CHK_EN
    , .o_err(err_a), .i_err_clr(err_clr)
`endif
  );

  micro_seq_v #(.DEPTH(DEPTH), .HOLD_CYC(HOLD_B), .GAP_CYC(GAP_B)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .i_req_class(req_class),
    .i_req_sel(req_sel), .o_req_ready(ready_b), .o_en(en_b), .o_code(code_b), .o_busy(busy_b)
`ifdef MICRO_SEQ_ILLEGAL_CHK_EN
    , .o_err(err_b), .i_err_clr(err_clr)
`endif
  );

  function automatic int hold_of(input int u);
    return (u == 0) ? HOLD_A : HOLD_B;
  endfunction

  function automatic int gap_of(input int u);
    return (u == 0) ? GAP_A : GAP_B;
  endfunction

  function automatic void ref_encode(input logic [1:0] c, input logic [1:0] s,
                                     output bit legal, output logic [3:0] code);
    legal = 1'b1;
    code  = 4'b0000;
    case ({c, s})
      4'b0000: code = 4'b1010;
      4'b0001: code = 4'b1011;
      4'b0010: code = 4'b1100;
      4'b0011: legal = 1'b0;
      4'b0100: code = 4'b0011;
      4'b0101: code = 4'b0100;
      4'b0110: code = 4'b0010;
      4'b0111: code = 4'b1110;
      4'b1000: code = 4'b1111;
      4'b1001, 4'b1010, 4'b1011: legal = 1'b0;
      default: code = 4'b0000;
    endcase
  endfunction

  function automatic bit m_en(input int u, input int tt);
    for (int i = 0; i < n_rec[u]; i++)
      if (tt >= rec_d[u][i] + 1 && tt <= rec_d[u][i] + hold_of(u)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_code(input int u, input int tt);
    for (int i = 0; i < n_rec[u]; i++)
      if (tt >= rec_d[u][i] + 1 && tt <= rec_d[u][i] + hold_of(u)) return rec_code[u][i];
    return 4'b0000;
  endfunction

  function automatic int m_occ(input int u, input int tt);
    int occ = 0;
    for (int i = 0; i < n_rec[u]; i++) begin
      if (rec_k[u][i] <= tt) occ++;
      if (rec_d[u][i] <= tt) occ--;
    end
    return occ;
  endfunction

  function automatic bit m_busy(input int u, input int tt);
    if (m_occ(u, tt) > 0) return 1'b1;
    for (int i = 0; i < n_rec[u]; i++)
      if (tt >= rec_d[u][i] && tt <= rec_d[u][i] + hold_of(u) + gap_of(u) - 1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit got_en(input int u);
    return (u == 0) ? en_a : en_b;
  endfunction

  function automatic logic [3:0] got_code(input int u);
    return (u == 0) ? code_a : code_b;
  endfunction

  function automatic bit got_ready(input int u);
    return (u == 0) ? ready_a : ready_b;
  endfunction

  function automatic bit got_busy(input int u);
    return (u == 0) ? busy_a : busy_b;
  endfunction

`ifdef MICRO_SEQ_ILLEGAL_CHK_EN
  function automatic bit got_err(input int u);
    return (u == 0) ? err_a : err_b;
  endfunction
`endif

  // Drive one cycle of stimulus from a falling edge, update the model, and
  // return at the next falling edge.
  task automatic step(input bit v, input logic [1:0] c, input logic [1:0] s, input bit clr);
    bit         legal;
    logic [3:0] code;
    int         k;
    int         d;
    ref_encode(c, s, legal, code);
    req_valid = v;
    req_class = c;
    req_sel   = s;
`ifdef MICRO_SEQ_ILLEGAL_CHK_EN
    err_clr = clr;
`endif
    k = t + 1;
    for (int u = 0; u < 2; u++) begin
      bit acc;
      bit enq;
      acc = v && (m_occ(u, t) < DEPTH);
      enq = acc;
`ifdef MICRO_SEQ_ILLEGAL_CHK_EN
      if (acc && !legal) begin
        enq = 1'b0;
        err_exp[u] = 1'b1;
      end else if (clr) begin
        err_exp[u] = 1'b0;
      end
`else
      if (clr) err_exp[u] = 1'b0;
`endif
      if (enq && n_rec[u] < MAXR) begin
        d = k + 1;
        if (n_rec[u] > 0 && rec_d[u][n_rec[u]-1] + hold_of(u) + gap_of(u) > d)
          d = rec_d[u][n_rec[u]-1] + hold_of(u) + gap_of(u);
        rec_k[u][n_rec[u]]    = k;
        rec_d[u][n_rec[u]]    = d;
        rec_code[u][n_rec[u]] = legal ? code : 4'b0000;
        n_rec[u]++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    req_valid = 1'b0;
    req_class = 2'd0;
    req_sel   = 2'd0;
`ifdef MICRO_SEQ_ILLEGAL_CHK_EN
    err_clr = 1'b0;
`endif
    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      n_rec[u]   = 0;
      err_exp[u] = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int u = 0; u < 2; u++) begin
      n_total++;
      if ({got_en(u), got_code(u), got_busy(u), got_ready(u)} !== 7'b0_0000_0_1) begin
        $display("[TB] FAIL reset_state dut%0d: en/code/busy/ready=%b/%b/%b/%b, expected 0/0000/0/1",
                 u, got_en(u), got_code(u), got_busy(u), got_ready(u));
      end else n_pass++;
`ifdef MICRO_SEQ_ILLEGAL_CHK_EN
      n_total++;
      if (got_err(u) !== 1'b0) $display("[TB] FAIL reset_err dut%0d: err=%b, expected 0", u, got_err(u));
      else n_pass++;
`endif
    end
  endtask

  task automatic test_single();
    do_reset();
    step(1'b1, 2'd0, 2'd1, 1'b0);
    for (int c = 0; c < 6; c++) begin
      for (int u = 0; u < 2; u++) begin
        n_total++;
        if (got_en(u) !== m_en(u, t) || got_code(u) !== m_code(u, t))
          $display("[TB] FAIL single_req dut%0d t=%0d: en=%b code=%b, expected en=%b code=%b",
                   u, t, got_en(u), got_code(u), m_en(u, t), m_code(u, t));
        else n_pass++;
      end
      if (c == 2) begin
        n_total++;
        if (en_a !== 1'b1 || code_a !== 4'b1011)
          $display("[TB] FAIL single_latency: en=%b code=%b two edges after accept, expected 1/1011",
                   en_a, code_a);
        else n_pass++;
      end
      step(1'b0, 2'd0, 2'd0, 1'b0);
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int c = 0; c < 30; c++) begin
      for (int u = 0; u < 2; u++) begin
        n_total++;
        if (got_ready(u) !== (m_occ(u, t) < DEPTH) || got_en(u) !== m_en(u, t) ||
            got_code(u) !== m_code(u, t))
          $display("[TB] FAIL fill dut%0d t=%0d: ready=%b en=%b code=%b, expected ready=%b en=%b code=%b",
                   u, t, got_ready(u), got_en(u), got_code(u), (m_occ(u, t) < DEPTH), m_en(u, t), m_code(u, t));
        else n_pass++;
      end
      step(c < 10, 2'd1, 2'(c), 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    int high_cnt = 0;
    do_reset();
    step(1'b1, 2'd1, 2'd0, 1'b0);
    step(1'b1, 2'd1, 2'd3, 1'b0);
    step(1'b1, 2'd2, 2'd0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      n_total++;
      if (en_b !== m_en(1, t) || code_b !== m_code(1, t))
        $display("[TB] FAIL back_to_back t=%0d: en=%b code=%b, expected en=%b code=%b",
                 t, en_b, code_b, m_en(1, t), m_code(1, t));
      else n_pass++;
      if (en_b === 1'b1) high_cnt++;
      step(1'b0, 2'd0, 2'd0, 1'b0);
    end
    n_total++;
    if (high_cnt !== 6) $display("[TB] FAIL back_to_back_len: en high %0d cycles, expected 6", high_cnt);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    step(1'b1, 2'd2, 2'd0, 1'b0);
    step(1'b1, 2'd1, 2'd1, 1'b0);
    step(1'b1, 2'd0, 2'd0, 1'b0);
    n_total++;
    if (en_b !== m_en(1, t) || code_b !== m_code(1, t))
      $display("[TB] FAIL pre_reset_drive: en=%b code=%b, expected en=%b code=%b",
               en_b, code_b, m_en(1, t), m_code(1, t));
    else n_pass++;
    #2;
    rst_n = 1'b0;
    req_valid = 1'b0;
    #1;
    n_total++;
    if ({en_a, code_a, en_b, code_b} !== 10'b0) 
      $display("[TB] FAIL async_reset_drop: en_a=%b code_a=%b en_b=%b code_b=%b, expected all 0",
               en_a, code_a, en_b, code_b);
    else n_pass++;
    for (int u = 0; u < 2; u++) begin
      n_rec[u]   = 0;
      err_exp[u] = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int u = 0; u < 2; u++) begin
      n_total++;
      if (got_busy(u) !== 1'b0 || got_ready(u) !== 1'b1 || got_en(u) !== 1'b0)
        $display("[TB] FAIL after_reset dut%0d: busy=%b ready=%b en=%b, expected 0/1/0",
                 u, got_busy(u), got_ready(u), got_en(u));
      else n_pass++;
    end
  endtask

  task automatic test_illegal();
    do_reset();
`ifdef MICRO_SEQ_ILLEGAL_CHK_EN
    step(1'b1, 2'd2, 2'd2, 1'b0);
    for (int c = 0; c < 4; c++) begin
      for (int u = 0; u < 2; u++) begin
        n_total++;
        if (got_err(u) !== 1'b1 || got_en(u) !== 1'b0 || got_busy(u) !== 1'b0)
          $display("[TB] FAIL illegal_drop dut%0d: err=%b en=%b busy=%b, expected 1/0/0",
                   u, got_err(u), got_en(u), got_busy(u));
        else n_pass++;
      end
      step(1'b0, 2'd0, 2'd0, 1'b0);
    end
    step(1'b0, 2'd0, 2'd0, 1'b1);
    n_total++;
    if (err_a !== 1'b0 || err_b !== 1'b0)
      $display("[TB] FAIL err_clear: err_a=%b err_b=%b, expected 0", err_a, err_b);
    else n_pass++;
    step(1'b1, 2'd0, 2'd3, 1'b1);
    n_total++;
    if (err_a !== 1'b1 || err_b !== 1'b1)
      $display("[TB] FAIL err_set_and_clr: err_a=%b err_b=%b, expected 1", err_a, err_b);
    else n_pass++;
`else
    step(1'b1, 2'd0, 2'd3, 1'b0);
    for (int c = 0; c < 5; c++) begin
      for (int u = 0; u < 2; u++) begin
        n_total++;
        if (got_en(u) !== m_en(u, t) || got_code(u) !== m_code(u, t))
          $display("[TB] FAIL illegal_as_nop dut%0d t=%0d: en=%b code=%b, expected en=%b code=%b",
                   u, t, got_en(u), got_code(u), m_en(u, t), m_code(u, t));
        else n_pass++;
      end
      if (c == 2) begin
        n_total++;
        if (en_a !== 1'b1 || code_a !== 4'b0000)
          $display("[TB] FAIL illegal_nop_issue: en=%b code=%b, expected 1/0000", en_a, code_a);
        else n_pass++;
      end
      step(1'b0, 2'd0, 2'd0, 1'b0);
    end
`endif
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int u = 0; u < 2; u++) begin
        n_total++;
        if (got_en(u) !== m_en(u, t) || got_code(u) !== m_code(u, t) ||
            got_ready(u) !== (m_occ(u, t) < DEPTH) || got_busy(u) !== m_busy(u, t))
          $display("[TB] FAIL random dut%0d t=%0d: en=%b code=%b ready=%b busy=%b, expected en=%b code=%b ready=%b busy=%b",
                   u, t, got_en(u), got_code(u), got_ready(u), got_busy(u),
                   m_en(u, t), m_code(u, t), (m_occ(u, t) < DEPTH), m_busy(u, t));
        else n_pass++;
`ifdef MICRO_SEQ_ILLEGAL_CHK_EN
        n_total++;
        if (got_err(u) !== err_exp[u])
          $display("[TB] FAIL random_err dut%0d t=%0d: err=%b, expected %b", u, t, got_err(u), err_exp[u]);
        else n_pass++;
`endif
      end
      step(c < 370 ? 1'($urandom_range(0, 1)) : 1'b0, 2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)), $urandom_range(0, 15) == 0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_async_reset();
    test_illegal();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
